// File: rtl/a1_bus_pkg.sv
// a1_bus_pkg: shared state encoding, open-bus default and region decode helper for the 6502 bus fabric
package a1_bus_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
    localparam logic [7:0] OPEN_BUS_DEF = 8'hFF;
    function automatic logic region_hit(input logic [15:0] ab, input logic [15:0] base, input logic [15:0] mask);
        return (ab & mask) == (base & mask);
    endfunction
endpackage

// File: rtl/a1_bus_fabric_if.sv
// a1_bus_fabric_if: CPU-side and slave-side bus signals of the fabric
// slave modport is the fabric itself; master modport is the environment driving it
interface a1_bus_fabric_if #(parameter int N_SLV = 8);
    logic               cpu_clken;
    logic [15:0]        ab;
    logic               we;
    logic [7:0]         dbo;
    logic [7:0]         dbi;
    logic               cpu_ready;
    logic [N_SLV-1:0]   slv_cs;
    logic [N_SLV-1:0]   slv_req;
    logic               slv_we;
    logic [15:0]        slv_addr;
    logic [7:0]         slv_wdata;
    logic [N_SLV-1:0]   slv_ack;
    logic [N_SLV*8-1:0] slv_rdata;
    modport slave (
        input  cpu_clken, ab, we, dbo, slv_ack, slv_rdata,
        output dbi, cpu_ready, slv_cs, slv_req, slv_we, slv_addr, slv_wdata
    );
    modport master (
        output cpu_clken, ab, we, dbo, slv_ack, slv_rdata,
        input  dbi, cpu_ready, slv_cs, slv_req, slv_we, slv_addr, slv_wdata
    );
endinterface

// File: rtl/a1_addr_decode.sv
// a1_addr_decode: priority address decode over parameter tables; lowest-index hitting slave wins
module a1_addr_decode
    import a1_bus_pkg::*;
#(
    parameter int                   N_SLV    = 8,
    parameter int                   IW       = 3,
    parameter logic [N_SLV*16-1:0]  SLV_BASE = {N_SLV{16'h0000}},
    parameter logic [N_SLV*16-1:0]  SLV_MASK = {N_SLV{16'hFFFF}},
    parameter logic [N_SLV-1:0]     SLV_HS   = {N_SLV{1'b0}}
) (
    input  logic [15:0]      ab_i,
    output logic [N_SLV-1:0] slv_cs_o,
    output logic [IW-1:0]    sel_idx_o,
    output logic             sel_hs_o,
    output logic             hit_o
);
    // scan high to low so the lowest hitting index overwrites the rest
    always_comb begin
        slv_cs_o  = '0;
        sel_idx_o = '0;
        sel_hs_o  = 1'b0;
        hit_o     = 1'b0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if (region_hit(ab_i, SLV_BASE[16*i +: 16], SLV_MASK[16*i +: 16])) begin
                slv_cs_o    = '0;
                slv_cs_o[i] = 1'b1;
                sel_idx_o   = IW'(i);
                sel_hs_o    = SLV_HS[i];
                hit_o       = 1'b1;
            end
        end
    end
endmodule

// File: rtl/a1_bus_fabric.sv
// a1_bus_fabric: 6502 bus fabric with region decode, read mux and wait-state handshake FSM
// optional access timeout with sticky bus_err when A1_BUS_TIMEOUT_EN is defined
module a1_bus_fabric
    import a1_bus_pkg::*;
#(
    parameter int                   N_SLV       = 8,
    parameter logic [N_SLV*16-1:0]  SLV_BASE    = {N_SLV{16'h0000}},
    parameter logic [N_SLV*16-1:0]  SLV_MASK    = {N_SLV{16'hFFFF}},
    parameter logic [N_SLV-1:0]     SLV_HS      = {N_SLV{1'b0}},
    parameter logic [7:0]           OPEN_BUS    = OPEN_BUS_DEF,
    parameter int                   TIMEOUT_CYC = 1023
) (
    input  logic              clk25,
    input  logic              rst_n,
    a1_bus_fabric_if.slave    bus,
    output logic              bus_err
);
    localparam int IW = (N_SLV > 1) ? $clog2(N_SLV) : 1;

    if (N_SLV < 1 || N_SLV > 16 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("a1_bus_fabric: N_SLV must be 1..16 and TIMEOUT_CYC >= 1");
    end

    logic [IW-1:0]    sel_idx;
    logic             sel_hs;
    logic             hit;
    state_e           state_q;
    logic [N_SLV-1:0] req_q;
    logic             we_q;
    logic [15:0]      addr_q;
    logic [7:0]       wdata_q;
    logic [IW-1:0]    idx_q;
    logic [7:0]       data_q;

    a1_addr_decode #(
        .N_SLV    (N_SLV),
        .IW       (IW),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK),
        .SLV_HS   (SLV_HS)
    ) u_dec (
        .ab_i      (bus.ab),
        .slv_cs_o  (bus.slv_cs),
        .sel_idx_o (sel_idx),
        .sel_hs_o  (sel_hs),
        .hit_o     (hit)
    );

`ifdef A1_BUS_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYC + 1) > 10) ? $clog2(TIMEOUT_CYC + 1) : 10;
    logic [CW-1:0] cnt_q;
    logic          err_q;
    assign bus_err = err_q;
`else
    assign bus_err = 1'b0;
`endif

    // request strobe and transaction fields are loaded on IDLE->REQ so they are visible during REQ
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
            data_q  <= OPEN_BUS;
`ifdef A1_BUS_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (sel_hs) begin
                    state_q <= REQ;
                    req_q   <= N_SLV'(1) << sel_idx;
                    addr_q  <= bus.ab;
                    we_q    <= bus.we;
                    wdata_q <= bus.dbo;
                    idx_q   <= sel_idx;
                end
                REQ: begin
                    state_q <= WAIT;
                    req_q   <= '0;
`ifdef A1_BUS_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                WAIT: begin
                    if (bus.slv_ack[idx_q]) begin
                        state_q <= DONE;
                        if (!we_q) data_q <= bus.slv_rdata[idx_q*8 +: 8];
                    end
`ifdef A1_BUS_TIMEOUT_EN
                    else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                        state_q <= DONE;
                        data_q  <= OPEN_BUS;
                        err_q   <= 1'b1;
                    end else cnt_q <= cnt_q + 1'b1;
`endif
                end
                DONE: if (bus.cpu_clken) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.slv_req   = req_q;
    assign bus.slv_we    = we_q;
    assign bus.slv_addr  = addr_q;
    assign bus.slv_wdata = wdata_q;
    assign bus.cpu_ready = ~(sel_hs & (state_q != DONE));
    assign bus.dbi       = sel_hs ? data_q : hit ? bus.slv_rdata[sel_idx*8 +: 8] : OPEN_BUS;
endmodule

// File: tb/tb_a1_bus_fabric.sv
// tb_a1_bus_fabric: directed checks of decode, read mux, handshake FSM, reset and optional timeout
module tb_a1_bus_fabric;
    logic clk25 = 1'b0;
    logic rst_n = 1'b0;
    logic bus_err, bus_err2;
    int   ntests = 0;
    int   nfail  = 0;

    always #20 clk25 = ~clk25;

    a1_bus_fabric_if #(.N_SLV(3)) bus ();
    a1_bus_fabric_if #(.N_SLV(3)) bus2 ();

    a1_bus_fabric #(
        .N_SLV       (3),
        .SLV_BASE    ({16'h8000, 16'hD010, 16'h0000}),
        .SLV_MASK    ({16'h8000, 16'hFFFE, 16'hE000}),
        .SLV_HS      (3'b100),
        .OPEN_BUS    (8'hFF),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk25   (clk25),
        .rst_n   (rst_n),
        .bus     (bus),
        .bus_err (bus_err)
    );

    a1_bus_fabric #(
        .N_SLV       (3),
        .SLV_BASE    ({16'h0000, 16'hD010, 16'hD000}),
        .SLV_MASK    ({16'h0000, 16'hFFFE, 16'hF000}),
        .SLV_HS      (3'b000),
        .OPEN_BUS    (8'hFF),
        .TIMEOUT_CYC (16)
    ) dut_ovl (
        .clk25   (clk25),
        .rst_n   (rst_n),
        .bus     (bus2),
        .bus_err (bus_err2)
    );

    task automatic test_reset();
        #5;
        ntests++; if (bus.slv_req !== 3'b000) begin nfail++; $display("FAIL rst_req: got %b exp 000", bus.slv_req); end
        ntests++; if (bus.slv_addr !== 16'h0000) begin nfail++; $display("FAIL rst_addr: got %h exp 0000", bus.slv_addr); end
        ntests++; if (bus.slv_we !== 1'b0 || bus.slv_wdata !== 8'h00) begin nfail++; $display("FAIL rst_we_wdata: got %b/%h exp 0/00", bus.slv_we, bus.slv_wdata); end
        ntests++; if (bus_err !== 1'b0) begin nfail++; $display("FAIL rst_err: got %b exp 0", bus_err); end
        ntests++; if (bus.cpu_ready !== 1'b1) begin nfail++; $display("FAIL rst_ready: got %b exp 1", bus.cpu_ready); end
        @(negedge clk25); rst_n = 1'b1;
    endtask

    task automatic test_zero_wait();
        int low = 0;
        int reqs = 0;
        @(posedge clk25); #1; bus.ab = 16'h1234;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk25); #1;
            bus.cpu_clken = ~bus.cpu_clken;
            if (bus.cpu_ready !== 1'b1) low++;
            if (bus.slv_req !== 3'b000) reqs++;
        end
        bus.cpu_clken = 1'b0; #1;
        ntests++; if (low != 0) begin nfail++; $display("FAIL zw_ready: got %0d low cycles exp 0", low); end
        ntests++; if (reqs != 0) begin nfail++; $display("FAIL zw_req: got %0d req cycles exp 0", reqs); end
        ntests++; if (bus.dbi !== 8'hA5) begin nfail++; $display("FAIL zw_dbi: got %h exp a5", bus.dbi); end
        ntests++; if (bus.slv_cs !== 3'b001) begin nfail++; $display("FAIL zw_cs: got %b exp 001", bus.slv_cs); end
        bus.ab = 16'hD011; #1;
        ntests++; if (bus.slv_cs !== 3'b010 || bus.dbi !== 8'h5A || bus.cpu_ready !== 1'b1) begin nfail++; $display("FAIL prio_d011: got cs=%b dbi=%h rdy=%b exp 010/5a/1", bus.slv_cs, bus.dbi, bus.cpu_ready); end
        bus.ab = 16'h4000; #1;
        ntests++; if (bus.slv_cs !== 3'b000 || bus.dbi !== 8'hFF || bus.cpu_ready !== 1'b1) begin nfail++; $display("FAIL miss: got cs=%b dbi=%h rdy=%b exp 000/ff/1", bus.slv_cs, bus.dbi, bus.cpu_ready); end
        bus.ab = 16'h0100;
    endtask

    task automatic test_overlap();
        bus2.ab = 16'hD010; #1;
        ntests++; if (bus2.slv_cs !== 3'b001 || bus2.dbi !== 8'h55) begin nfail++; $display("FAIL ovl_d010: got cs=%b dbi=%h exp 001/55", bus2.slv_cs, bus2.dbi); end
        bus2.ab = 16'h1234; #1;
        ntests++; if (bus2.slv_cs !== 3'b100 || bus2.dbi !== 8'h77) begin nfail++; $display("FAIL ovl_1234: got cs=%b dbi=%h exp 100/77", bus2.slv_cs, bus2.dbi); end
    endtask

    task automatic test_hs_read();
        int pulses = 0;
        int high = 0;
        @(posedge clk25); #1;
        bus.ab = 16'h9000; bus.we = 1'b0; bus.cpu_clken = 1'b0; bus.slv_ack = 3'b000;
        #1;
        ntests++; if (bus.cpu_ready !== 1'b0) begin nfail++; $display("FAIL hs_stall_start: got %b exp 0", bus.cpu_ready); end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk25); #1;
            if (bus.slv_req[2] === 1'b1) pulses++;
            if (bus.cpu_ready !== 1'b0) high++;
        end
        bus.slv_rdata[23:16] = 8'h3C; bus.slv_ack = 3'b100;
        @(posedge clk25); #1;
        bus.slv_ack = 3'b000; bus.slv_rdata[23:16] = 8'h00; #1;
        ntests++; if (high != 0) begin nfail++; $display("FAIL hs_stall: got %0d ready cycles exp 0", high); end
        ntests++; if (pulses != 1) begin nfail++; $display("FAIL hs_req_pulses: got %0d exp 1", pulses); end
        ntests++; if (bus.slv_addr !== 16'h9000 || bus.slv_we !== 1'b0) begin nfail++; $display("FAIL hs_addr: got %h/%b exp 9000/0", bus.slv_addr, bus.slv_we); end
        ntests++; if (bus.cpu_ready !== 1'b1) begin nfail++; $display("FAIL hs_done_ready: got %b exp 1", bus.cpu_ready); end
        bus.cpu_clken = 1'b1; #1;
        ntests++; if (bus.dbi !== 8'h3C) begin nfail++; $display("FAIL hs_dbi: got %h exp 3c", bus.dbi); end
        @(posedge clk25); #1;
        bus.cpu_clken = 1'b0; bus.ab = 16'h0100; #1;
        ntests++; if (bus.cpu_ready !== 1'b1 || bus.slv_req !== 3'b000) begin nfail++; $display("FAIL hs_after: got rdy=%b req=%b exp 1/000", bus.cpu_ready, bus.slv_req); end
    endtask

    task automatic test_hs_write();
        int pulses = 0;
        bus.slv_rdata[23:16] = 8'h77;
        @(posedge clk25); #1;
        bus.ab = 16'h9001; bus.we = 1'b1; bus.dbo = 8'h55;
        @(posedge clk25); #1;
        ntests++; if (bus.slv_we !== 1'b1 || bus.slv_wdata !== 8'h55 || bus.slv_addr !== 16'h9001 || bus.slv_req !== 3'b100) begin nfail++; $display("FAIL wr_latch: got we=%b wd=%h a=%h req=%b exp 1/55/9001/100", bus.slv_we, bus.slv_wdata, bus.slv_addr, bus.slv_req); end
        @(posedge clk25); #1;
        bus.slv_ack = 3'b100;
        @(posedge clk25); #1;
        ntests++; if (bus.cpu_ready !== 1'b1) begin nfail++; $display("FAIL wr_ready: got %b exp 1", bus.cpu_ready); end
        ntests++; if (bus.dbi !== 8'h3C) begin nfail++; $display("FAIL wr_nocapture: got %h exp 3c", bus.dbi); end
        bus.cpu_clken = 1'b1;
        @(posedge clk25); #1;
        bus.cpu_clken = 1'b0; bus.ab = 16'h0100; bus.we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk25); #1;
            if (bus.slv_req !== 3'b000) pulses++;
        end
        bus.slv_ack = 3'b000;
        ntests++; if (pulses != 0) begin nfail++; $display("FAIL wr_level_ack: got %0d extra req cycles exp 0", pulses); end
    endtask

    task automatic test_ack_filter();
        bus.slv_rdata[23:16] = 8'hC3;
        @(posedge clk25); #1;
        bus.ab = 16'h9000; bus.we = 1'b0;
        @(posedge clk25); #1;
        bus.slv_ack = 3'b100;
        @(posedge clk25); #1;
        bus.slv_ack = 3'b001;
        repeat (2) @(posedge clk25);
        #1;
        ntests++; if (bus.cpu_ready !== 1'b0) begin nfail++; $display("FAIL ack_filter: got ready %b exp 0", bus.cpu_ready); end
        bus.slv_ack = 3'b100;
        @(posedge clk25); #1;
        bus.slv_ack = 3'b000; #1;
        ntests++; if (bus.cpu_ready !== 1'b1 || bus.dbi !== 8'hC3) begin nfail++; $display("FAIL ack_own: got rdy=%b dbi=%h exp 1/c3", bus.cpu_ready, bus.dbi); end
        bus.cpu_clken = 1'b1;
        @(posedge clk25); #1;
        bus.cpu_clken = 1'b0; bus.ab = 16'h0100;
    endtask

    task automatic test_reset_mid();
        @(posedge clk25); #1;
        bus.ab = 16'h9000; bus.we = 1'b0;
        repeat (3) @(posedge clk25);
        #1;
        rst_n = 1'b0; #1;
        ntests++; if (bus.slv_req !== 3'b000 || bus.slv_addr !== 16'h0000) begin nfail++; $display("FAIL rmid_clear: got req=%b a=%h exp 000/0000", bus.slv_req, bus.slv_addr); end
        ntests++; if (bus.cpu_ready !== 1'b0) begin nfail++; $display("FAIL rmid_ready_hs: got %b exp 0", bus.cpu_ready); end
        bus.slv_rdata[23:16] = 8'hEE; bus.slv_ack = 3'b100;
        @(posedge clk25); #1;
        bus.slv_ack = 3'b000; #1;
        ntests++; if (bus.dbi !== 8'hFF || bus.cpu_ready !== 1'b0) begin nfail++; $display("FAIL rmid_ack_ignored: got dbi=%h rdy=%b exp ff/0", bus.dbi, bus.cpu_ready); end
        bus.ab = 16'h0100; #1;
        ntests++; if (bus.cpu_ready !== 1'b1) begin nfail++; $display("FAIL rmid_ready_zw: got %b exp 1", bus.cpu_ready); end
        @(negedge clk25); rst_n = 1'b1;
        @(posedge clk25); #1;
        ntests++; if (bus.slv_req !== 3'b000) begin nfail++; $display("FAIL rmid_after: got req=%b exp 000", bus.slv_req); end
    endtask

`ifdef A1_BUS_TIMEOUT_EN
    task automatic test_timeout();
        int high = 0;
        @(posedge clk25); #1;
        bus.ab = 16'h9000; bus.we = 1'b0; bus.slv_ack = 3'b000;
        for (int i = 0; i < 17; i++) begin
            @(posedge clk25); #1;
            if (bus.cpu_ready !== 1'b0) high++;
        end
        ntests++; if (high != 0 || bus_err !== 1'b0) begin nfail++; $display("FAIL to_wait: got %0d ready cycles err=%b exp 0/0", high, bus_err); end
        @(posedge clk25); #1;
        ntests++; if (bus.cpu_ready !== 1'b1 || bus.dbi !== 8'hFF || bus_err !== 1'b1) begin nfail++; $display("FAIL to_done: got rdy=%b dbi=%h err=%b exp 1/ff/1", bus.cpu_ready, bus.dbi, bus_err); end
        bus.cpu_clken = 1'b1;
        @(posedge clk25); #1;
        bus.cpu_clken = 1'b0; bus.ab = 16'h0100;
        @(posedge clk25); #1;
        bus.ab = 16'h9000;
        repeat (2) @(posedge clk25);
        #1;
        bus.slv_rdata[23:16] = 8'h3C; bus.slv_ack = 3'b100;
        @(posedge clk25); #1;
        bus.slv_ack = 3'b000; #1;
        ntests++; if (bus.dbi !== 8'h3C || bus_err !== 1'b1) begin nfail++; $display("FAIL to_sticky: got dbi=%h err=%b exp 3c/1", bus.dbi, bus_err); end
        bus.cpu_clken = 1'b1;
        @(posedge clk25); #1;
        bus.cpu_clken = 1'b0; bus.ab = 16'h0100;
    endtask
`endif

    initial begin
        bus.cpu_clken = 1'b0; bus.ab = 16'h0000; bus.we = 1'b0; bus.dbo = 8'h00;
        bus.slv_ack = 3'b000; bus.slv_rdata = 24'h00_5A_A5;
        bus2.cpu_clken = 1'b0; bus2.ab = 16'h0000; bus2.we = 1'b0; bus2.dbo = 8'h00;
        bus2.slv_ack = 3'b000; bus2.slv_rdata = 24'h77_66_55;
        test_reset();
        test_zero_wait();
        test_overlap();
        test_hs_read();
        test_hs_write();
        test_ack_filter();
        test_reset_mid();
`ifdef A1_BUS_TIMEOUT_EN
        test_timeout();
`else
        ntests++; if (bus_err !== 1'b0) begin nfail++; $display("FAIL err_tied: got %b exp 0", bus_err); end
`endif
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/a1_bus_fabric.md
Name: a1_bus_fabric

Overview:
- Parametrised 6502 bus fabric; successor to the fixed address decode and data-in mux in the Apple-1 top.
- Decodes N_SLV address regions from parameter tables and drives one-hot chip selects.
- Muxes slave read data to the CPU, with priority by slave index and an open-bus value on a miss.
- Adds wait-state handshake slaves (e.g. SDRAM-backed 32K RAM) by stretching cpu_ready until the slave acks.
- Sits between arlet_6502 and all memories and peripherals.

Parameters:
- N_SLV, 8: number of slave regions (1..16).
- SLV_BASE, {N_SLV{16'h0000}}: packed N_SLV×16 base addresses; slave i occupies [16*i+:16].
- SLV_MASK, {N_SLV{16'hFFFF}}: packed N_SLV×16 compare masks; hit_i = ((ab & mask_i) == (base_i & mask_i)).
- SLV_HS, {N_SLV{1'b0}}: packed N_SLV bits; 1 = handshake (wait-state) slave, 0 = zero-wait slave.
- OPEN_BUS, 8'hFF: dbi value on a decode miss or a timed-out access.
- TIMEOUT_CYC, 1023: clk25 cycles allowed in WAIT before abort (only with A1_BUS_TIMEOUT_EN).

Ports:
- clk25  in  1  master clock.
- rst_n  in  1  asynchronous active-low reset.
- cpu_clken  in  1  CPU clock enable.
- ab  in  16  CPU address.
- we  in  1  CPU write strobe.
- dbo  in  8  CPU write data.
- dbi  out  8  CPU read data.
- cpu_ready  out  1  to arlet_6502 ready (ANDed with cpu_clken at top level).
- slv_cs  out  N_SLV  one-hot chip select, combinational.
- slv_req  out  N_SLV  one-cycle request pulse, handshake slaves only.
- slv_we  out  1  latched write flag for the handshake transaction.
- slv_addr  out  16  latched address for the handshake transaction.
- slv_wdata  out  8  latched write data for the handshake transaction.
- slv_ack  in  N_SLV  slave completion; one-cycle pulse or level.
- slv_rdata  in  N_SLV*8  packed slave read data.
- bus_err  out  1  sticky timeout flag (A1_BUS_TIMEOUT_EN only; otherwise tied 0).

Behaviour:
- Decode:
  - Lowest-index hitting slave wins; slv_cs is one-hot or zero.
  - sel_idx and sel_hs are derived from the winning slave.
- Zero-wait slave: dbi = slv_rdata[sel], cpu_ready = 1, fully combinational.
- Miss: dbi = OPEN_BUS, cpu_ready = 1.
- FSM states: IDLE, REQ, WAIT, DONE.
  - Reset: IDLE; slv_req=0, slv_we=0, slv_addr=0, slv_wdata=0, data latch=OPEN_BUS, bus_err=0.
  - IDLE→REQ when sel_hs. No cpu_clken qualification; the CPU has already presented the address.
  - REQ: latch ab/we/dbo/sel_idx into the slv_* outputs. Assert slv_req[sel_idx] for exactly this one cycle. →WAIT.
  - WAIT: on slv_ack[latched idx], capture slv_rdata of that slave into the data latch and →DONE. Writes capture nothing. Acks from other slaves are ignored.
  - DONE: hold until cpu_clken=1, then →IDLE in that same cycle.
- Combinational outputs:
  - cpu_ready = ~(sel_hs & state != DONE). The stall starts in the same cycle the handshake slave is first selected.
  - dbi = data latch while a handshake slave is selected.
- Latency: minimum 3 clk25 cycles of stall (IDLE, REQ, WAIT with immediate ack), then the DONE wait for clken.
- An ack arriving in the REQ cycle is ignored; it is only sampled in WAIT.
- Level acks: DONE→IDLE does not re-request, because the CPU address advances on that clken. A repeat access to the same handshake slave starts a fresh transaction.
- Reset asserted mid-transaction: immediate return to IDLE; slv_req drops; any late ack is ignored.
- ab changing during WAIT is illegal (the CPU is stalled) and is not checked.

Optional Feature:
- Macro: A1_BUS_TIMEOUT_EN.
- With it defined:
  - A 10-bit-minimum counter (width $clog2(TIMEOUT_CYC+1)) clears in REQ and counts in WAIT.
  - When it reaches TIMEOUT_CYC: →DONE, data latch = OPEN_BUS, bus_err set (sticky until reset).
- Without it: WAIT persists until ack, bus_err is constant 0, and no counter logic exists.

Decomposition:
- Package a1_bus_pkg:
  - State enum (IDLE/REQ/WAIT/DONE).
  - OPEN_BUS default constant.
  - Function region_hit(ab, base, mask).
- Sub-module a1_addr_decode (combinational): parameter tables and ab in; slv_cs, sel_idx, sel_hs, hit out.
- The FSM and the read mux stay in a1_bus_fabric.

Test Plan:
- N_SLV=3, RAM 0x0000/mask 0xE000 zero-wait; read 0x1234 with slv_rdata0=0xA5 → dbi=0xA5, cpu_ready never low.
- Overlapping regions, slave0 base 0xD000/mask 0xF000 and slave1 0xD010/mask 0xFFFE; read 0xD010 → slv_cs=3'b001.
- Handshake slave 2 at 0x8000/mask 0x8000; read 0x9000, ack after 5 cycles with 0x3C:
  - one slv_req pulse; slv_addr=0x9000.
  - cpu_ready low until DONE, then dbi=0x3C on the next clken.
- Write 0x55 to 0x9001 on handshake slave:
  - slv_we=1, slv_wdata=0x55.
  - After ack, cpu_ready high; no second slv_req while ack is held high.
- Reset asserted 2 cycles into WAIT, then ack → state IDLE, slv_req=0, ack ignored, cpu_ready follows decode.
- A1_BUS_TIMEOUT_EN, TIMEOUT_CYC=16, no ack:
  - after 16 WAIT cycles, DONE with dbi=0xFF and bus_err=1.
  - bus_err stays 1 across a later successful access.
